// File: rtl/mock_stream_gen_if.sv
// Control, read-strobe and FIFO status bundle for mock_stream_gen.
// master = generator side, slave = consumer/controller side.
interface mock_stream_gen_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              en;
  logic              clr;
  logic              mode;
  logic [15:0]       rate_div;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_out;
  logic [CNT_W-1:0]  rd_data_count;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              udf;

  modport master (
    input  en, clr, mode, rate_div, fifo_rd,
    output fifo_out, rd_data_count, empty, full, ovf, udf
  );

  modport slave (
    output en, clr, mode, rate_div, fifo_rd,
    input  fifo_out, rd_data_count, empty, full, ovf, udf
  );
endinterface

// File: rtl/mock_stream_gen.sv
// Deterministic multi-channel sample generator feeding an internal FIFO.
// Optional LFSR payload pattern built only when MOCK_STREAM_LFSR_EN is defined.
module mock_stream_gen #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned NUM_CH = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  mock_stream_gen_if.master  bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned PAY_W = DATA_W - 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PUSH, S_STALL} state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_rate_cnt, w_rate_cnt_nxt;
  logic [7:0]        r_ch;
  logic [PAY_W-1:0]  r_sample;
  logic [PAY_W-1:0]  w_payload;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [DATA_W-1:0] r_out;
  logic              r_empty, r_full, r_ovf, r_udf;
  logic              w_rd, w_wr, w_stall, w_can_wr, w_frame_end;

`ifdef MOCK_STREAM_LFSR_EN
  function automatic logic [63:0] tap_bit(input int unsigned t);
    return 64'(1) << (t - 1);
  endfunction

  // Maximal-length Fibonacci tap sets, tap n is the MSB of an n-bit register.
  function automatic logic [63:0] lfsr_taps(input int unsigned w);
    logic [63:0] m;
    m = '0;
    case (w)
      8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
      9:  m = tap_bit(9)  | tap_bit(5);
      10: m = tap_bit(10) | tap_bit(7);
      11: m = tap_bit(11) | tap_bit(9);
      12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
      14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
      15: m = tap_bit(15) | tap_bit(14);
      16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: m = tap_bit(17) | tap_bit(14);
      18: m = tap_bit(18) | tap_bit(11);
      19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      20: m = tap_bit(20) | tap_bit(17);
      21: m = tap_bit(21) | tap_bit(19);
      22: m = tap_bit(22) | tap_bit(21);
      23: m = tap_bit(23) | tap_bit(18);
      24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25: m = tap_bit(25) | tap_bit(22);
      26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
      28: m = tap_bit(28) | tap_bit(25);
      29: m = tap_bit(29) | tap_bit(27);
      30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      31: m = tap_bit(31) | tap_bit(28);
      32: m = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
      33: m = tap_bit(33) | tap_bit(20);
      34: m = tap_bit(34) | tap_bit(27) | tap_bit(2)  | tap_bit(1);
      35: m = tap_bit(35) | tap_bit(33);
      36: m = tap_bit(36) | tap_bit(25);
      37: m = tap_bit(37) | tap_bit(5)  | tap_bit(4)  | tap_bit(3) | tap_bit(2) | tap_bit(1);
      38: m = tap_bit(38) | tap_bit(6)  | tap_bit(5)  | tap_bit(1);
      39: m = tap_bit(39) | tap_bit(35);
      40: m = tap_bit(40) | tap_bit(38) | tap_bit(21) | tap_bit(19);
      41: m = tap_bit(41) | tap_bit(38);
      42: m = tap_bit(42) | tap_bit(41) | tap_bit(20) | tap_bit(19);
      43: m = tap_bit(43) | tap_bit(42) | tap_bit(38) | tap_bit(37);
      44: m = tap_bit(44) | tap_bit(43) | tap_bit(18) | tap_bit(17);
      45: m = tap_bit(45) | tap_bit(44) | tap_bit(42) | tap_bit(41);
      46: m = tap_bit(46) | tap_bit(45) | tap_bit(26) | tap_bit(25);
      47: m = tap_bit(47) | tap_bit(42);
      48: m = tap_bit(48) | tap_bit(47) | tap_bit(21) | tap_bit(20);
      49: m = tap_bit(49) | tap_bit(40);
      50: m = tap_bit(50) | tap_bit(49) | tap_bit(24) | tap_bit(23);
      51: m = tap_bit(51) | tap_bit(50) | tap_bit(36) | tap_bit(35);
      52: m = tap_bit(52) | tap_bit(49);
      53: m = tap_bit(53) | tap_bit(52) | tap_bit(38) | tap_bit(37);
      54: m = tap_bit(54) | tap_bit(53) | tap_bit(18) | tap_bit(17);
      55: m = tap_bit(55) | tap_bit(31);
      56: m = tap_bit(56) | tap_bit(55) | tap_bit(35) | tap_bit(34);
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [PAY_W-1:0] TAP_MASK = PAY_W'(lfsr_taps(PAY_W));

  logic [PAY_W-1:0] r_lfsr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                 r_lfsr <= PAY_W'(1);
    else if (bus.clr)           r_lfsr <= PAY_W'(1);
    else if (w_wr && w_frame_end)
      r_lfsr <= {r_lfsr[PAY_W-2:0], ^(r_lfsr & TAP_MASK)};
  end

  assign w_payload = bus.mode ? r_lfsr : r_sample;
`else
  logic w_unused_mode;
  assign w_unused_mode = bus.mode;
  assign w_payload     = r_sample;
`endif

  assign w_word      = {r_ch, w_payload};
  assign w_frame_end = (r_ch == 8'(NUM_CH - 1));
  assign w_rd        = bus.fifo_rd && !r_empty && !bus.clr;
  // A same-cycle read frees a slot, so a full FIFO still accepts the write.
  assign w_can_wr    = !r_full || w_rd;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_rate_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rate_cnt <= w_rate_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rate_cnt_nxt = r_rate_cnt;
    w_wr           = 1'b0;
    w_stall        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rate_cnt_nxt = '0;
        if (bus.en) w_state_nxt = S_PUSH;
      end
      S_WAIT: begin
        if (!bus.en) begin
          w_state_nxt    = S_IDLE;
          w_rate_cnt_nxt = '0;
        end else if (17'(r_rate_cnt) + 17'd1 >= 17'(bus.rate_div)) begin
          w_state_nxt    = S_PUSH;
          w_rate_cnt_nxt = '0;
        end else begin
          w_rate_cnt_nxt = r_rate_cnt + 16'd1;
        end
      end
      S_PUSH, S_STALL: begin
        w_rate_cnt_nxt = '0;
        if (r_state == S_STALL && !bus.en) begin
          w_state_nxt = S_IDLE;
        end else if (w_can_wr) begin
          w_wr = 1'b1;
          if (!bus.en)                  w_state_nxt = S_IDLE;
          else if (bus.rate_div == '0)  w_state_nxt = S_PUSH;
          else                          w_state_nxt = S_WAIT;
        end else begin
          w_stall     = bus.en;
          w_state_nxt = bus.en ? S_STALL : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.clr) begin
      w_state_nxt    = S_IDLE;
      w_rate_cnt_nxt = '0;
      w_wr           = 1'b0;
      w_stall        = 1'b0;
    end
  end

  assign w_count_nxt = r_count + CNT_W'(w_wr) - CNT_W'(w_rd);

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr <= '0; r_rptr <= '0; r_count <= '0;
      r_empty <= 1'b1; r_full <= 1'b0; r_ovf <= 1'b0; r_udf <= 1'b0;
      r_out <= '0; r_ch <= '0; r_sample <= '0;
    end else if (bus.clr) begin
      r_wptr <= '0; r_rptr <= '0; r_count <= '0;
      r_empty <= 1'b1; r_full <= 1'b0; r_ovf <= 1'b0; r_udf <= 1'b0;
      r_out <= '0; r_ch <= '0; r_sample <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
        if (w_frame_end) begin
          r_ch     <= '0;
          r_sample <= r_sample + PAY_W'(1);
        end else begin
          r_ch     <= r_ch + 8'd1;
        end
      end
      if (w_rd) begin
        r_out  <= r_mem[r_rptr];
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (bus.fifo_rd && r_empty) r_udf <= 1'b1;
      if (w_stall)                r_ovf <= 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  assign bus.fifo_out      = r_out;
  assign bus.rd_data_count = r_count;
  assign bus.empty         = r_empty;
  assign bus.full          = r_full;
  assign bus.ovf           = r_ovf;
  assign bus.udf           = r_udf;
endmodule

// File: tb/tb_mock_stream_gen.sv
// Directed self-checking bench for mock_stream_gen (DATA_W=32, DEPTH=128, NUM_CH=4).
module tb_mock_stream_gen;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mock_stream_gen_if #(.DATA_W(32), .DEPTH(128)) bus ();

  mock_stream_gen #(.DATA_W(32), .DEPTH(128), .NUM_CH(4)) u_dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Counter-pattern word for the j-th generated sample.
  function automatic logic [31:0] cword(input int j);
    return {8'(j % 4), 24'(j / 4)};
  endfunction

  initial begin
    int maxc;
    int idx;
    logic prev_rd;
    logic [23:0] lfsr;
    logic [31:0] expw;

    rst_n = 1'b0;
    bus.en = 1'b0; bus.clr = 1'b0; bus.mode = 1'b0;
    bus.rate_div = 16'd0; bus.fifo_rd = 1'b0;
    step(3);
    chk("rst_out",   64'(bus.fifo_out), 64'h0);
    chk("rst_count", 64'(bus.rd_data_count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full",  64'(bus.full), 64'd0);
    chk("rst_ovf",   64'(bus.ovf), 64'd0);
    chk("rst_udf",   64'(bus.udf), 64'd0);

    // Fill at full rate with no reads
    rst_n = 1'b1; bus.en = 1'b1;
    step(140);
    chk("fill_count", 64'(bus.rd_data_count), 64'd128);
    chk("fill_full",  64'(bus.full), 64'd1);
    chk("fill_empty", 64'(bus.empty), 64'd0);
    chk("fill_ovf",   64'(bus.ovf), 64'd1);

    // Read held high at full: simultaneous read/write, count pinned at 128
    bus.fifo_rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("full_rw_data",  64'(bus.fifo_out), 64'(cword(i)));
      chk("full_rw_count", 64'(bus.rd_data_count), 64'd128);
    end

    // Disable; the in-flight push (word 136) completes, then drain everything
    bus.en = 1'b0;
    for (int i = 8; i <= 136; i++) begin
      step(1);
      chk("drain_data", 64'(bus.fifo_out), 64'(cword(i)));
    end
    bus.fifo_rd = 1'b0;
    chk("drain_count", 64'(bus.rd_data_count), 64'd0);
    chk("drain_empty", 64'(bus.empty), 64'd1);
    chk("drain_udf",   64'(bus.udf), 64'd0);

    // Underflow
    bus.fifo_rd = 1'b1; step(1); bus.fifo_rd = 1'b0;
    chk("udf_flag",  64'(bus.udf), 64'd1);
    chk("udf_out",   64'(bus.fifo_out), 64'(cword(136)));
    chk("udf_count", 64'(bus.rd_data_count), 64'd0);

    // Enable one cycle (writes ch1), pause 20 cycles, enable again (writes ch2)
    bus.en = 1'b1; step(1); bus.en = 1'b0;
    step(20);
    chk("pause_count", 64'(bus.rd_data_count), 64'd1);
    bus.en = 1'b1; step(1); bus.en = 1'b0;
    step(3);
    chk("resume_count", 64'(bus.rd_data_count), 64'd2);
    bus.fifo_rd = 1'b1;
    step(1); chk("resume_w0", 64'(bus.fifo_out), 64'(cword(137)));
    step(1); chk("resume_w1", 64'(bus.fifo_out), 64'h0200_0022);
    bus.fifo_rd = 1'b0;

    // Synchronous clear
    chk("pre_clr_ovf", 64'(bus.ovf), 64'd1);
    chk("pre_clr_udf", 64'(bus.udf), 64'd1);
    bus.clr = 1'b1; step(1); bus.clr = 1'b0;
    chk("clr_udf",   64'(bus.udf), 64'd0);
    chk("clr_ovf",   64'(bus.ovf), 64'd0);
    chk("clr_count", 64'(bus.rd_data_count), 64'd0);
    chk("clr_empty", 64'(bus.empty), 64'd1);
    chk("clr_out",   64'(bus.fifo_out), 64'h0);
    bus.en = 1'b1; step(2); bus.en = 1'b0;
    step(2);
    chk("clr_wr_count", 64'(bus.rd_data_count), 64'd2);
    bus.fifo_rd = 1'b1;
    step(1); chk("clr_first", 64'(bus.fifo_out), 64'h0000_0000);
    step(1); chk("clr_second", 64'(bus.fifo_out), 64'h0100_0000);
    bus.fifo_rd = 1'b0;

    // rate_div=3 with threshold drain
    bus.clr = 1'b1; step(1); bus.clr = 1'b0;
    bus.rate_div = 16'd3; bus.en = 1'b1;
    step(10);
    chk("rate_count", 64'(bus.rd_data_count), 64'd3);
    maxc = 3; idx = 0; prev_rd = 1'b0;
    for (int c = 0; c < 300; c++) begin
      bus.fifo_rd = (bus.rd_data_count > 10);
      prev_rd = bus.fifo_rd;
      step(1);
      if (prev_rd) begin
        chk("rate_data", 64'(bus.fifo_out), 64'(cword(idx)));
        idx++;
      end
      if (int'(bus.rd_data_count) > maxc) maxc = int'(bus.rd_data_count);
    end
    bus.fifo_rd = 1'b0; bus.en = 1'b0;
    chk("rate_max_count", 64'(maxc), 64'd11);
    chk("rate_ovf", 64'(bus.ovf), 64'd0);
    chk("rate_udf", 64'(bus.udf), 64'd0);

    // mode=1 for 1000 frames
    step(2);
    bus.clr = 1'b1; step(1); bus.clr = 1'b0;
    bus.mode = 1'b1; bus.rate_div = 16'd0; bus.en = 1'b1;
    step(2);
    bus.fifo_rd = 1'b1;
    lfsr = 24'd1;
    for (int k = 0; k < 4000; k++) begin
      if (k % 4 == 0 && k != 0) lfsr = {lfsr[22:0], lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};
`ifdef MOCK_STREAM_LFSR_EN
      expw = {8'(k % 4), lfsr};
`else
      expw = cword(k);
`endif
      step(1);
      chk("mode1_data", 64'(bus.fifo_out), 64'(expw));
    end
    bus.fifo_rd = 1'b0; bus.en = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
